// File: rtl/calc_op_sequencer.sv
// -----------------------------------------------------------------------------
// calc_op_sequencer
//
// Purpose:
//   Control FSM for the calculator datapath (input register, ALU mux,
//   accumulator, opcode register, display mux). Converts one-cycle key
//   strobes into datapath load/clear/select controls. Handles multi-cycle
//   ALU opcodes, traps divide-by-zero, and drives one-hot phase LEDs.
//   Every output is a Moore decode of the registered state, so a key sampled
//   at edge t shows its effect on the controls for the cycle after t.
//
// Optional feature (compile-time macro):
//   CALC_CHAIN_EN - when defined, key_op in READY_B executes the pending
//                   operation and then loads the new operator
//                   (EXEC -> WB -> LD_OP), and key_op in SHOW chains on the
//                   result. When undefined, key_op is ignored in READY_B and
//                   SHOW and no chain flag exists.
//
// Parameters:
//   MULTI_CYCLES - EXEC cycles before write-back for multi-cycle opcodes (>=1)
//   MC_MASK      - bit i set marks opcode i as multi-cycle
//   DIV_OP       - opcode that is trapped when the divisor is zero
//
// Ports:
//   i_clk              system clock
//   i_rst_n            asynchronous active-low reset (state forced to CLR)
//   i_key_num          strobe: operand valid on datapath input
//   i_key_op           strobe: operator valid on opcode input
//   i_key_eq           strobe: equals
//   i_key_clr          strobe: clear all (highest priority)
//   i_op_code_reg      current opcode register contents
//   i_divisor_zero     datapath input register is zero
//   o_load_number      load input register
//   o_clear_number     clear input register
//   o_load_opcode      load opcode register
//   o_clear_opcode     clear opcode register
//   o_sel_mux_alu      0: input register -> accumulator, 1: ALU result
//   o_load_result      load accumulator
//   o_clear_result     clear accumulator
//   o_sel_mux_display  0: show input register, 1: show accumulator
//   o_busy             high in EXEC and WB
//   o_err              high in ERR
//   o_s0..o_s3         one-hot phase: operand A / operator / operand B / result
// -----------------------------------------------------------------------------
module calc_op_sequencer #(
  parameter int unsigned MULTI_CYCLES = 4,
  parameter logic [7:0]  MC_MASK      = 8'b0001_1000,
  parameter logic [2:0]  DIV_OP       = 3'd4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_num,
  input  logic       i_key_op,
  input  logic       i_key_eq,
  input  logic       i_key_clr,
  input  logic [2:0] i_op_code_reg,
  input  logic       i_divisor_zero,
  output logic       o_load_number,
  output logic       o_clear_number,
  output logic       o_load_opcode,
  output logic       o_clear_opcode,
  output logic       o_sel_mux_alu,
  output logic       o_load_result,
  output logic       o_clear_result,
  output logic       o_sel_mux_display,
  output logic       o_busy,
  output logic       o_err,
  output logic       o_s0,
  output logic       o_s1,
  output logic       o_s2,
  output logic       o_s3
);

  localparam int unsigned CntW = (MULTI_CYCLES > 1) ? $clog2(MULTI_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MULTI_CYCLES - 1);

  typedef enum logic [3:0] {
    StClr    = 4'd0,
    StWaitA  = 4'd1,
    StLdA    = 4'd2,
    StXferA  = 4'd3,
    StWaitOp = 4'd4,
    StLdOp   = 4'd5,
    StWaitB  = 4'd6,
    StLdB    = 4'd7,
    StReadyB = 4'd8,
    StExec   = 4'd9,
    StWb     = 4'd10,
    StShow   = 4'd11,
    StErr    = 4'd12
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic            w_div_err;
  logic            w_multi;

`ifdef CALC_CHAIN_EN
  // Set when key_op triggered the execute; WB then goes to LD_OP, not SHOW.
  logic r_chain;
  logic w_chain_nxt;
`endif

  assign w_div_err = (i_op_code_reg == DIV_OP) && i_divisor_zero;
  assign w_multi   = MC_MASK[i_op_code_reg];

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StClr;
      r_cnt   <= '0;
`ifdef CALC_CHAIN_EN
      r_chain <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef CALC_CHAIN_EN
      r_chain <= w_chain_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority among keys: clr > eq > op > num.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
`ifdef CALC_CHAIN_EN
    w_chain_nxt = r_chain;
`endif

    if (i_key_clr) begin
      w_state_nxt = StClr;
    end else begin
      unique case (r_state)
        StClr:    w_state_nxt = StWaitA;
        StWaitA:  if (i_key_num) w_state_nxt = StLdA;
        StLdA:    w_state_nxt = StXferA;
        StXferA:  w_state_nxt = StWaitOp;
        StWaitOp: begin
          if (i_key_op)       w_state_nxt = StLdOp;
          else if (i_key_num) w_state_nxt = StLdA;
        end
        StLdOp:   w_state_nxt = StWaitB;
        StWaitB: begin
          if (i_key_op)       w_state_nxt = StLdOp;
          else if (i_key_num) w_state_nxt = StLdB;
        end
        StLdB:    w_state_nxt = StReadyB;
        StReadyB: begin
          if (i_key_eq) begin
            w_state_nxt = StExec;
`ifdef CALC_CHAIN_EN
          end else if (i_key_op) begin
            w_state_nxt = StExec;
            w_chain_nxt = 1'b1;
`endif
          end else if (i_key_num) begin
            w_state_nxt = StLdB;
          end
        end
        StExec: begin
          // Divide-by-zero is only judged in the first EXEC cycle, before any
          // write-back can happen.
          if ((r_cnt == '0) && w_div_err) begin
            w_state_nxt = StErr;
          end else if (w_multi && (r_cnt != CntLast)) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end else begin
            w_state_nxt = StWb;
          end
        end
        StWb: begin
`ifdef CALC_CHAIN_EN
          if (r_chain) begin
            w_state_nxt = StLdOp;
            w_chain_nxt = 1'b0;
          end else begin
            w_state_nxt = StShow;
          end
`else
          w_state_nxt = StShow;
`endif
        end
        StShow: begin
          if (i_key_eq) begin
            w_state_nxt = StExec;
`ifdef CALC_CHAIN_EN
          end else if (i_key_op) begin
            w_state_nxt = StLdOp;
`endif
          end else if (i_key_num) begin
            w_state_nxt = StLdA;
          end
        end
        StErr:    w_state_nxt = StErr;
        default:  w_state_nxt = StClr;
      endcase
    end

    // Counter is held at zero outside EXEC, so every EXEC entry starts fresh.
    if (w_state_nxt != StExec) begin
      w_cnt_nxt = '0;
    end

`ifdef CALC_CHAIN_EN
    // An aborted operation must not chain later.
    if ((w_state_nxt == StClr) || (w_state_nxt == StErr)) begin
      w_chain_nxt = 1'b0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    o_load_number     = 1'b0;
    o_clear_number    = 1'b0;
    o_load_opcode     = 1'b0;
    o_clear_opcode    = 1'b0;
    o_sel_mux_alu     = 1'b0;
    o_load_result     = 1'b0;
    o_clear_result    = 1'b0;
    o_sel_mux_display = 1'b0;
    o_busy            = 1'b0;
    o_err             = 1'b0;
    o_s0              = 1'b0;
    o_s1              = 1'b0;
    o_s2              = 1'b0;
    o_s3              = 1'b0;

    unique case (r_state)
      StClr: begin
        o_clear_number = 1'b1;
        o_clear_opcode = 1'b1;
        o_clear_result = 1'b1;
        o_s0           = 1'b1;
      end
      StWaitA: o_s0 = 1'b1;
      StLdA: begin
        o_load_number = 1'b1;
        o_s0          = 1'b1;
      end
      StXferA: begin
        // sel_mux_alu stays 0: operand A goes straight into the accumulator.
        o_load_result = 1'b1;
        o_s0          = 1'b1;
      end
      StWaitOp: begin
        o_sel_mux_display = 1'b1;
        o_s1              = 1'b1;
      end
      StLdOp: begin
        o_load_opcode = 1'b1;
        o_s1          = 1'b1;
      end
      StWaitB: o_s2 = 1'b1;
      StLdB: begin
        o_load_number = 1'b1;
        o_s2          = 1'b1;
      end
      StReadyB: o_s2 = 1'b1;
      StExec: begin
        o_sel_mux_alu = 1'b1;
        o_busy        = 1'b1;
        o_s3          = 1'b1;
      end
      StWb: begin
        o_load_result = 1'b1;
        o_sel_mux_alu = 1'b1;
        o_busy        = 1'b1;
        o_s3          = 1'b1;
      end
      StShow: begin
        o_sel_mux_display = 1'b1;
        o_s3              = 1'b1;
      end
      StErr: begin
        o_err             = 1'b1;
        o_sel_mux_display = 1'b1;
        o_s3              = 1'b1;
      end
      default: o_s0 = 1'b1;
    endcase
  end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Controller that sequences the calculator datapath: input register, ALU mux, accumulator, opcode register and display mux. It turns single-cycle key strobes (number, operator, equals, clear) into datapath load/clear/select controls. It supports multi-cycle ALU operations, divide-by-zero error trapping and one-hot phase outputs for the status LEDs. It replaces ad-hoc key handling in front of the datapath.

Parameters:
MULTI_CYCLES, 4, EXEC cycles before write-back for multi-cycle opcodes (≥1)
MC_MASK, 8'b0001_1000, bit i set means opcode i is multi-cycle
DIV_OP, 3'd4, opcode checked against divisor_zero

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
key_num  in  1  one-cycle strobe: operand value valid on datapath input
key_op  in  1  one-cycle strobe: operator valid on opcode input
key_eq  in  1  one-cycle strobe: equals
key_clr  in  1  one-cycle strobe: clear all
op_code_reg  in  3  current opcode register contents from datapath
divisor_zero  in  1  datapath input register == 0
load_number, clear_number, load_opcode, clear_opcode  out  1 each  datapath register controls
sel_muxAlu  out  1  0 = pass input register to accumulator, 1 = ALU result
load_result, clear_result  out  1 each  accumulator controls
sel_muxDisplay  out  1  0 = show input register, 1 = show accumulator
busy  out  1  high in EXEC and WB
err  out  1  high in ERR
S0, S1, S2, S3  out  1 each  one-hot phase: operand A / operator / operand B / result

Behaviour:
- All outputs are Moore decodes of a registered state. During reset the state is CLR.
- Key priority: clr > eq > op > num. key_clr moves any state to CLR on the next edge.
- States, their asserted outputs (all others 0) and transitions:
  - CLR: clear_number, clear_opcode, clear_result, S0. Next: WAIT_A.
  - WAIT_A: S0. key_num → LD_A.
  - LD_A: load_number, S0. Next: XFER_A.
  - XFER_A: load_result, sel_muxAlu=0, S0. Next: WAIT_OP.
  - WAIT_OP: sel_muxDisplay, S1. key_op → LD_OP; key_num → LD_A (replace A).
  - LD_OP: load_opcode, S1. Next: WAIT_B.
  - WAIT_B: S2. key_num → LD_B; key_op → LD_OP (replace operator).
  - LD_B: load_number, S2. Next: READY_B.
  - READY_B: S2. key_eq → EXEC; key_num → LD_B; key_op → EXEC with chain flag set (see optional feature).
  - EXEC: sel_muxAlu, busy, S3.
    - First cycle: if op_code_reg==DIV_OP and divisor_zero → ERR, with no accumulator write.
    - Otherwise, if MC_MASK[op_code_reg] → stay MULTI_CYCLES cycles total, then WB.
    - Otherwise → WB after 1 cycle.
    - The cycle counter resets on every EXEC entry.
  - WB: load_result, sel_muxAlu, busy, S3. Next: LD_OP if chain flag (flag cleared), else SHOW.
  - SHOW: sel_muxDisplay, S3. key_num → LD_A (new calculation); key_eq → EXEC (repeat last op with the held B); key_op → LD_OP (chain on result).
  - ERR: err, sel_muxDisplay, S3. Only key_clr exits.
- Keys other than key_clr arriving in CLR, LD_*, XFER_A, EXEC or WB are dropped. No queuing.
- Key-to-control latency is exactly 1 cycle. Example: key_num sampled high at edge t in WAIT_A gives load_number high for the cycle after t.
- Exactly one of S0..S3 is high at all times, including during reset (S0).
- Reset asserted mid-EXEC aborts the operation with no load_result pulse. The chain flag and counter clear.

Optional Feature:
CALC_CHAIN_EN
- Defined: key_op in READY_B executes the pending operation and then loads the new operator (EXEC→WB→LD_OP→WAIT_B). key_op in SHOW goes to LD_OP.
- Undefined: key_op is ignored in READY_B and SHOW, and the chain flag logic is absent. Only key_eq executes. A new calculation starts only via key_num or key_clr.

Test Plan:
- Reset low 3 cycles, then release → clear_* high for 1 cycle, S0=1, then WAIT_A. No load pulses.
- key_num, key_op (opcode 0), key_num, key_eq → load_number, load_result(sel 0), load_opcode, load_number, then single-cycle EXEC, then load_result(sel 1). Ends in SHOW with S3=1 and sel_muxDisplay=1.
- Opcode 3 with MULTI_CYCLES=4 → busy high exactly 5 cycles (4 EXEC + 1 WB); load_result only in the WB cycle.
- Opcode 4 with divisor_zero=1, then key_eq → ERR with err=1 and no load_result. key_num/key_op/key_eq are ignored; key_clr → CLR → WAIT_A.
- key_clr and key_eq in the same cycle in READY_B → CLR wins; no EXEC.
- CALC_CHAIN_EN defined: A, op, B, key_op → EXEC, WB, LD_OP, WAIT_B with S2=1. Undefined: same stimulus stays in READY_B.
